// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared frame geometry, FSM encoding and bit-map helper for the dual-channel ADC reader
package adc_spi_pkg;

    localparam int FRAME_BITS = 34;
    localparam int CH_BITS    = 14;
    localparam int CH_A_FIRST = 2;
    localparam int CH_B_FIRST = 18;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t CONV  = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

    typedef struct packed {
        logic keep;
        logic ch_b;
    } bit_sel_t;

    function automatic bit_sel_t bit_is_kept(input logic [5:0] k, input int data_w);
        int       ja;
        int       jb;
        bit_sel_t s;
        ja     = int'(k) - CH_A_FIRST;
        jb     = int'(k) - CH_B_FIRST;
        s.ch_b = jb >= 0;
        s.keep = (ja >= 0 && ja < data_w) || (jb >= 0 && jb < data_w);
        return s;
    endfunction

endpackage

// File: rtl/adc_sck_timer.sv
// adc_sck_timer: half-period and bit counters producing a registered SCK plus frame timing strobes
module adc_sck_timer
    import adc_spi_pkg::*;
#(
    parameter int SCK_HALF = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       shift,
    output logic       sck,
    output logic       rise_strobe,
    output logic       period_end,
    output logic       frame_end,
    output logic [5:0] bit_idx
);

    localparam int HW = SCK_HALF > 1 ? $clog2(SCK_HALF) : 1;

    logic [HW-1:0] half_cnt;
    logic          phase;
    logic          half_end;

    assign half_end    = half_cnt == HW'(SCK_HALF - 1);
    assign rise_strobe = run && shift && half_end && !phase;
    assign period_end  = run && half_end && phase;
    assign frame_end   = shift && period_end && bit_idx == 6'(FRAME_BITS - 1);

    // counters idle at zero outside CONV/SHIFT; SCK only toggles while shifting
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            half_cnt <= '0;
            phase    <= 1'b0;
            bit_idx  <= '0;
            sck      <= 1'b0;
        end else begin
            half_cnt <= half_end ? '0 : half_cnt + HW'(1);
            phase    <= phase ^ half_end;
            bit_idx  <= (shift && period_end) ? bit_idx + 6'd1 : bit_idx;
            sck      <= shift && (phase ^ half_end);
        end
    end

endmodule

// File: rtl/adc_spi_dual_capture.sv
// adc_spi_dual_capture: frame FSM and two-channel capture for the 14-bit dual serial ADC
module adc_spi_dual_capture
    import adc_spi_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int SCK_HALF = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              spi_miso,
    output logic              ad_conv,
    output logic              spi_sck,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              valid,
    output logic              busy,
    output logic              start_drop
);

    if (DATA_W < 1 || DATA_W > CH_BITS || SCK_HALF < 1) begin : g_bad_param
        $error("adc_spi_dual_capture: illegal DATA_W or SCK_HALF");
    end

    state_t            state;
    state_t            state_nx;
    logic              shift;
    logic              rise;
    logic              period_end;
    logic              frame_end;
    logic [5:0]        bit_idx;
    bit_sel_t          sel;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;

    assign busy    = state != IDLE;
    assign ad_conv = state == CONV;
    assign shift   = state == SHIFT;
    assign sel     = bit_is_kept(bit_idx, DATA_W);

    adc_sck_timer #(.SCK_HALF(SCK_HALF)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .run         (ad_conv || shift),
        .shift       (shift),
        .sck         (spi_sck),
        .rise_strobe (rise),
        .period_end  (period_end),
        .frame_end   (frame_end),
        .bit_idx     (bit_idx)
    );

    // frame sequencing: conversion pulse, 34-bit shift, one-cycle done
    always_comb begin
        state_nx = state == IDLE  ? ((start || continuous) ? CONV : IDLE) :
                   state == CONV  ? (period_end ? SHIFT : CONV) :
                   state == SHIFT ? (frame_end ? DONE : SHIFT) :
                                    (continuous ? CONV : IDLE);
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // shift the kept MSBs of each channel in on every SCK rising edge
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_a <= '0;
            cap_b <= '0;
        end else if (rise && sel.keep) begin
            if (sel.ch_b) cap_b <= (cap_b << 1) | DATA_W'(spi_miso);
            else          cap_a <= (cap_a << 1) | DATA_W'(spi_miso);
        end
    end

    // publish results as the FSM enters DONE; flag starts that cannot be honoured
    always_ff @(posedge clock) begin
        if (reset) begin
            data_a     <= '0;
            data_b     <= '0;
            valid      <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            valid      <= frame_end;
            start_drop <= start && busy && !(state == DONE && continuous);
            if (frame_end) begin
                data_a <= cap_a;
                data_b <= cap_b;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_dual_capture.sv
// tb_adc_spi_dual_capture: randomized frames against a bit-level ADC model and arithmetic reference
module tb_adc_spi_dual_capture;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, cont0 = 1'b0, cont1 = 1'b0;
    logic miso0, miso1, ad0, ad1, sck0, sck1, valid0, valid1, busy0, busy1, drop0, drop1;
    logic [11:0] da0, db0;
    logic [13:0] da1, db1;
    logic [33:0] fr0 = '0, fr1 = '0;
    logic [5:0]  r0 = '0, r1 = '0;
    logic        sq0 = 1'b0, sq1 = 1'b0;
    logic        sel = 1'b0;
    logic        m_ad, m_sck, m_valid, m_busy, m_drop;
    logic [13:0] m_da, m_db;
    int vectors = 0, miscompares = 0;
    int m_tv, m_nv, m_cf, m_cl, m_rises, m_hmin, m_hmax, m_lmin, m_lmax, m_drops;
    logic        m_be;
    logic [13:0] g_da, g_db;

    always #5 clock = ~clock;

    adc_spi_dual_capture #(.DATA_W(12), .SCK_HALF(1)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0), .continuous(cont0), .spi_miso(miso0),
        .ad_conv(ad0), .spi_sck(sck0), .data_a(da0), .data_b(db0), .valid(valid0),
        .busy(busy0), .start_drop(drop0));

    adc_spi_dual_capture #(.DATA_W(14), .SCK_HALF(3)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .continuous(cont1), .spi_miso(miso1),
        .ad_conv(ad1), .spi_sck(sck1), .data_a(da1), .data_b(db1), .valid(valid1),
        .busy(busy1), .start_drop(drop1));

    // ADC pin models: frame bit k is presented until SCK rise k, then the next bit follows
    always @(posedge clock) begin
        r0  <= ad0 ? 6'd0 : (sck0 && !sq0) ? r0 + 6'd1 : r0;
        sq0 <= sck0;
        r1  <= ad1 ? 6'd0 : (sck1 && !sq1) ? r1 + 6'd1 : r1;
        sq1 <= sck1;
    end

    assign miso0   = r0 > 6'd33 ? 1'b0 : fr0[r0];
    assign miso1   = r1 > 6'd33 ? 1'b0 : fr1[r1];
    assign m_ad    = sel ? ad1 : ad0;
    assign m_sck   = sel ? sck1 : sck0;
    assign m_valid = sel ? valid1 : valid0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_drop  = sel ? drop1 : drop0;
    assign m_da    = sel ? da1 : {2'b00, da0};
    assign m_db    = sel ? db1 : {2'b00, db0};

    function automatic logic [33:0] build(input logic [13:0] a, input logic [13:0] b, input logic [5:0] ign);
        logic [33:0] f;
        f = '0;
        f[0] = ign[0]; f[1] = ign[1]; f[16] = ign[2]; f[17] = ign[3]; f[32] = ign[4]; f[33] = ign[5];
        for (int i = 0; i < 14; i++) begin
            f[2 + i]  = a[13 - i];
            f[18 + i] = b[13 - i];
        end
        return f;
    endfunction

    function automatic logic [13:0] keep_msbs(input logic [13:0] v, input int dw);
        return v >> (14 - dw);
    endfunction

    task automatic set_frame(input logic [13:0] a, input logic [13:0] b, input logic [5:0] ign);
        if (sel) fr1 = build(a, b, ign);
        else     fr0 = build(a, b, ign);
    endtask

    task automatic set_start(input logic v);
        start0 = !sel && v;
        start1 = sel && v;
    endtask

    // pulse start on the selected DUT and record timing/data over one frame window
    task automatic run_frame(input int h, input int drop_n);
        int   run_len;
        logic prev;
        m_tv = -1; m_nv = 0; m_cf = -1; m_cl = 0; m_rises = 0; m_drops = 0;
        m_hmin = 1 << 20; m_hmax = 0; m_lmin = 1 << 20; m_lmax = 0;
        g_da = '0; g_db = '0; m_be = 1'b1;
        run_len = 0; prev = 1'b0;
        @(negedge clock); set_start(1'b1);
        @(negedge clock); set_start(1'b0);
        for (int n = 0; n < 70 * h + 8; n++) begin
            if (m_ad) begin
                if (m_cl == 0) m_cf = n;
                m_cl++;
            end
            if (m_sck !== prev) begin
                if (prev) begin
                    if (run_len < m_hmin) m_hmin = run_len;
                    if (run_len > m_hmax) m_hmax = run_len;
                end else if (m_rises > 0) begin
                    if (run_len < m_lmin) m_lmin = run_len;
                    if (run_len > m_lmax) m_lmax = run_len;
                end
                if (m_sck) m_rises++;
                prev = m_sck;
                run_len = 1;
            end else run_len++;
            if (m_valid) begin
                if (m_nv == 0) begin m_tv = n; g_da = m_da; g_db = m_db; end
                m_nv++;
            end
            if (m_drop) m_drops++;
            m_be = m_busy;
            set_start(n == drop_n);
            @(negedge clock);
        end
        set_start(1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({ad0, sck0, da0, db0, valid0, busy0, drop0} !== '0) begin
            miscompares++;
            $display("FAIL reset_dut0 ad=%b sck=%b a=%h b=%h v=%b busy=%b drop=%b want all 0", ad0, sck0, da0, db0, valid0, busy0, drop0);
        end
        vectors++;
        if ({ad1, sck1, da1, db1, valid1, busy1, drop1} !== '0) begin
            miscompares++;
            $display("FAIL reset_dut1 ad=%b sck=%b a=%h b=%h v=%b busy=%b drop=%b want all 0", ad1, sck1, da1, db1, valid1, busy1, drop1);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        sel = 1'b0;
        set_frame(14'h1ABC, 14'h3FFF, 6'h00);
        run_frame(1, -1);
        vectors++; if (m_tv !== 70) begin miscompares++; $display("FAIL basic_latency got %0d want 70", m_tv); end
        vectors++; if (m_cf !== 0 || m_cl !== 2) begin miscompares++; $display("FAIL basic_conv first=%0d len=%0d want 0/2", m_cf, m_cl); end
        vectors++; if (m_rises !== 34) begin miscompares++; $display("FAIL basic_sck_pulses got %0d want 34", m_rises); end
        vectors++; if (m_hmin !== 1 || m_hmax !== 1 || m_lmin !== 1 || m_lmax !== 1) begin miscompares++; $display("FAIL basic_sck_shape hi=%0d..%0d lo=%0d..%0d want 1", m_hmin, m_hmax, m_lmin, m_lmax); end
        vectors++; if (m_nv !== 1) begin miscompares++; $display("FAIL basic_valid_count got %0d want 1", m_nv); end
        vectors++; if (g_da !== 14'h6AF || g_db !== 14'hFFF) begin miscompares++; $display("FAIL basic_data a=%h b=%h want 6af/fff", g_da, g_db); end
        vectors++; if (m_drops !== 0 || m_be !== 1'b0) begin miscompares++; $display("FAIL basic_idle drops=%0d busy=%b want 0/0", m_drops, m_be); end
    endtask

    task automatic test_wide;
        sel = 1'b1;
        set_frame(14'h0001, 14'h2000, 6'h00);
        run_frame(3, -1);
        vectors++; if (m_tv !== 210) begin miscompares++; $display("FAIL wide_latency got %0d want 210", m_tv); end
        vectors++; if (m_cl !== 6) begin miscompares++; $display("FAIL wide_conv_len got %0d want 6", m_cl); end
        vectors++; if (m_rises !== 34) begin miscompares++; $display("FAIL wide_sck_pulses got %0d want 34", m_rises); end
        vectors++; if (m_hmin !== 3 || m_hmax !== 3 || m_lmin !== 3 || m_lmax !== 3) begin miscompares++; $display("FAIL wide_sck_shape hi=%0d..%0d lo=%0d..%0d want 3", m_hmin, m_hmax, m_lmin, m_lmax); end
        vectors++; if (g_da !== 14'h0001 || g_db !== 14'h2000) begin miscompares++; $display("FAIL wide_data a=%h b=%h want 0001/2000", g_da, g_db); end
    endtask

    task automatic test_ignored;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            set_frame(14'h0000, 14'h0000, 6'h3F);
            run_frame(s == 1 ? 3 : 1, -1);
            vectors++; if (g_da !== 14'h0 || g_db !== 14'h0 || m_nv !== 1) begin miscompares++; $display("FAIL ignored_bits dut%0d a=%h b=%h valids=%0d want 0/0/1", s, g_da, g_db, m_nv); end
        end
    endtask

    task automatic test_random;
        logic [13:0] a, b;
        int          h, dw;
        for (int i = 0; i < 6; i++) begin
            sel = i[0];
            h   = sel ? 3 : 1;
            dw  = sel ? 14 : 12;
            a   = 14'($urandom);
            b   = 14'($urandom);
            set_frame(a, b, 6'($urandom));
            run_frame(h, -1);
            vectors++; if (g_da !== keep_msbs(a, dw) || g_db !== keep_msbs(b, dw)) begin miscompares++; $display("FAIL random_data%0d a=%h b=%h want %h/%h", i, g_da, g_db, keep_msbs(a, dw), keep_msbs(b, dw)); end
            vectors++; if (m_tv !== 70 * h || m_nv !== 1) begin miscompares++; $display("FAIL random_timing%0d t=%0d n=%0d want %0d/1", i, m_tv, m_nv, 70 * h); end
        end
    endtask

    task automatic test_start_drop;
        logic [13:0] a, b;
        sel = 1'b0;
        a = 14'($urandom); b = 14'($urandom);
        set_frame(a, b, 6'($urandom));
        run_frame(1, 23);
        vectors++; if (m_drops !== 1) begin miscompares++; $display("FAIL drop_shift got %0d pulses want 1", m_drops); end
        vectors++; if (m_tv !== 70 || m_nv !== 1 || g_da !== keep_msbs(a, 12) || g_db !== keep_msbs(b, 12)) begin miscompares++; $display("FAIL drop_frame t=%0d n=%0d a=%h b=%h want 70/1/%h/%h", m_tv, m_nv, g_da, g_db, keep_msbs(a, 12), keep_msbs(b, 12)); end
        run_frame(1, 70);
        vectors++; if (m_drops !== 1 || m_be !== 1'b0 || m_cl !== 2) begin miscompares++; $display("FAIL drop_done drops=%0d busy=%b conv=%0d want 1/0/2", m_drops, m_be, m_cl); end
    endtask

    task automatic test_abort;
        logic [13:0] a, b;
        int          nv, nb;
        sel = 1'b0;
        set_frame(14'h3FFF, 14'h3FFF, 6'h00);
        @(negedge clock); start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        repeat (43) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        vectors++;
        if ({ad0, sck0, busy0, valid0, da0, db0} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs ad=%b sck=%b busy=%b v=%b a=%h b=%h want all 0", ad0, sck0, busy0, valid0, da0, db0);
        end
        nv = 0; nb = 0;
        repeat (80) begin
            if (valid0) nv++;
            if (busy0) nb++;
            @(negedge clock);
        end
        vectors++; if (nv !== 0 || nb !== 0) begin miscompares++; $display("FAIL abort_quiet valids=%0d busy_cycles=%0d want 0/0", nv, nb); end
        a = 14'($urandom); b = 14'($urandom);
        set_frame(a, b, 6'($urandom));
        run_frame(1, -1);
        vectors++; if (m_tv !== 70 || g_da !== keep_msbs(a, 12) || g_db !== keep_msbs(b, 12)) begin miscompares++; $display("FAIL abort_restart t=%0d a=%h b=%h want 70/%h/%h", m_tv, g_da, g_db, keep_msbs(a, 12), keep_msbs(b, 12)); end
    endtask

    task automatic test_continuous;
        logic [13:0] ca[3], cb[3];
        logic [11:0] ga[3], gb[3];
        int          tv[3];
        int          nv, drops, late;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ca[i] = 14'($urandom); cb[i] = 14'($urandom);
            tv[i] = -1; ga[i] = '0; gb[i] = '0;
        end
        set_frame(ca[0], cb[0], 6'($urandom));
        nv = 0; drops = 0; late = 0;
        @(negedge clock); start0 = 1'b1; cont0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (valid0) begin
                if (nv < 3) begin tv[nv] = n; ga[nv] = da0; gb[nv] = db0; end
                nv++;
                if (nv < 3) set_frame(ca[nv], cb[nv], 6'($urandom));
            end
            if (drop0) drops++;
            if (n >= 213 && (ad0 || busy0)) late++;
            start0 = n == 141;
            cont0  = n < 150;
            @(negedge clock);
        end
        start0 = 1'b0; cont0 = 1'b0;
        vectors++; if (nv !== 3) begin miscompares++; $display("FAIL cont_valid_count got %0d want 3", nv); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (tv[i] !== 70 + 71 * i) begin miscompares++; $display("FAIL cont_time%0d got %0d want %0d", i, tv[i], 70 + 71 * i); end
            vectors++; if ({2'b00, ga[i]} !== keep_msbs(ca[i], 12) || {2'b00, gb[i]} !== keep_msbs(cb[i], 12)) begin miscompares++; $display("FAIL cont_data%0d a=%h b=%h want %h/%h", i, ga[i], gb[i], keep_msbs(ca[i], 12), keep_msbs(cb[i], 12)); end
        end
        vectors++; if (drops !== 0) begin miscompares++; $display("FAIL cont_no_drop got %0d pulses want 0", drops); end
        vectors++; if (late !== 0) begin miscompares++; $display("FAIL cont_stops got %0d busy/conv cycles after last frame want 0", late); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wide;
        test_ignored;
        test_random;
        test_start_drop;
        test_abort;
        test_continuous;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_spi_dual_capture.md
Name: adc_spi_dual_capture

Overview:
- Parametrised successor to the single-channel SPI ADC reader for the two-channel 14-bit serial ADC (AD_CONV pulse, then a 34-bit SCK frame).
- Captures both channels and keeps the DATA_W MSBs of each.
- SCK is generated as a registered, divided signal, not a gated clock.
- Supports single-shot (start) and continuous modes with a valid strobe. Sits between the ADC pins and the sample-processing logic.

Parameters:
- DATA_W, 12, bits kept per channel (MSBs of the 14-bit word); legal 1..14.
- SCK_HALF, 1, system clocks per SCK half-period; legal >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request for one conversion frame
- continuous  in  1  when high, frames repeat back-to-back without start
- spi_miso  in  1  serial data from ADC
- ad_conv  out  1  conversion pulse to ADC
- spi_sck  out  1  SPI clock to ADC, registered
- data_a  out  DATA_W  channel A result, MSB-first truncation
- data_b  out  DATA_W  channel B result
- valid  out  1  one-cycle strobe: data_a/data_b updated
- busy  out  1  high in any state other than IDLE
- start_drop  out  1  one-cycle pulse: start arrived while busy (ignored)

Behaviour:
- Reset values: ad_conv=0, spi_sck=0, data_a=0, data_b=0, valid=0, busy=0, start_drop=0; FSM=IDLE, all counters 0.
- Reset is synchronous. Asserted mid-frame, it aborts the frame in the same edge: no valid, outputs return to reset values.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE -> CONV when start=1 or continuous=1.
- CONV: ad_conv=1, spi_sck=0 for 2*SCK_HALF clocks, then SHIFT.
- SHIFT: 34 SCK periods, bit index k = 0..33.
  - Each period: spi_sck=0 for SCK_HALF clocks, then 1 for SCK_HALF clocks.
  - spi_miso is sampled on the clock edge that drives spi_sck 0->1.
  - After k=33 high half completes, go to DONE with spi_sck=0.
- Bit map:
  - k=0,1: ignored.
  - k=2..15: channel A bit 13..0.
  - k=16,17: ignored.
  - k=18..31: channel B bit 13..0.
  - k=32,33: ignored.
  - Only the first DATA_W bits of each channel are shifted into the capture registers; the rest are discarded.
- DONE: one clock.
  - data_a/data_b load from the capture registers and valid=1 in that same cycle (registered outputs).
  - Next state is CONV if continuous=1, else IDLE.
- Latency: start sampled in IDLE at edge t -> ad_conv high from t+1 -> valid high at cycle t+1+70*SCK_HALF (SCK_HALF=1: t+71).
- Frame period in continuous mode: 70*SCK_HALF+1 clocks.
- Start handling:
  - start while busy=1 -> start_drop pulses one cycle; the frame in progress is unaffected.
  - start in the DONE cycle is also dropped, unless continuous=1, in which case the next frame is already scheduled and no drop pulse is issued.
  - start and continuous both high in IDLE -> a single frame begins; no drop.
- continuous deasserted mid-frame: the current frame completes with valid, then the FSM returns to IDLE.
- Data outputs hold their last value until the next DONE. valid never asserts for an aborted frame.
- Widths:
  - Half-period counter: clog2(SCK_HALF) bits (min 1).
  - Bit counter: 6 bits, wraps only via the FSM.
  - Capture shift registers: DATA_W each.

Decomposition:
- Package adc_spi_pkg:
  - FRAME_BITS=34, CH_BITS=14, CH_A_FIRST=2, CH_B_FIRST=18
  - state typedef {IDLE, CONV, SHIFT, DONE}
  - function bit_is_kept(k, DATA_W) returning channel select and kept flag
- Sub-module adc_sck_timer:
  - half-period counter plus 6-bit SCK bit counter
  - outputs sck level, rise_strobe, frame_end
  - FSM and capture logic stay in the top.

Test Plan:
1. SCK_HALF=1, DATA_W=12; ADC model drives A=14'h1ABC, B=14'h3FFF; start at t -> ad_conv high t+1..t+2, 34 SCK pulses, valid at t+71, data_a=12'h6AF, data_b=12'hFFF.
2. DATA_W=14, SCK_HALF=3; A=14'h0001, B=14'h2000 -> data_a=14'h0001, data_b=14'h2000, valid at t+211; SCK high/low exactly 3 clocks each.
3. continuous=1 for 3 frames (SCK_HALF=1), then drop continuous -> valid pulses spaced 71 clocks; after the third valid, busy=0 and ad_conv stays 0.
4. start pulse at SHIFT k=10 -> start_drop=1 for one cycle; data and valid timing identical to the undisturbed frame.
5. reset asserted at SHIFT k=20 -> next cycle ad_conv=0, spi_sck=0, busy=0, data=0; no valid; a new start then yields a correct frame.
6. Model drives ignored bits (k=0,1,16,17,32,33) as 1 and channel bits as 0 -> data_a=data_b=0.
